// File: rtl/dir_lut_sweep_ctrl.sv
// Walks all 256 direction-offset LUT addresses, adds each signed offset to a latched base bin,
// wraps the result into [0, NBINS) and streams {bin, idx, last} under valid/ready backpressure.
module dir_lut_sweep_ctrl #(
  parameter int NBINS = 36,
  parameter int BIN_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] base_bin,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       lut_addr,
  input  logic [4:0]       lut_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIN_W-1:0] out_bin,
  output logic [7:0]       out_idx,
  output logic             out_last
);

  localparam int SW = BIN_W + 2;
  localparam logic signed [SW-1:0] NB_S = SW'(NBINS);
  localparam logic [BIN_W:0]       NB_B = (BIN_W + 1)'(NBINS);

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

  state_t            state, state_d;
  logic [7:0]        addr;
  logic [BIN_W-1:0]  base;
  logic              accept, load, fin, kill, err_d;
  logic signed [SW-1:0] sum, wrapped;

  // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    load    = 1'b0;
    fin     = 1'b0;
    kill    = 1'b0;
    err_d   = 1'b0;
    case (state)
      IDLE: begin
        // abort wins over a same-cycle start
        if (start && !abort) begin
          if ({1'b0, base_bin} < NB_B) begin
            accept  = 1'b1;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          kill    = 1'b1;
          state_d = IDLE;
        end else if (!out_valid || out_ready) begin
          load = 1'b1;
          if (addr == 8'hff) state_d = LAST;
        end
      end
      LAST: begin
        if (abort) begin
          kill    = 1'b1;
          state_d = IDLE;
        end else if (out_valid && out_ready) begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Offset is sign-extended to BIN_W+2 bits; one correction step suffices since |offset| <= 16 <= NBINS.
  always_comb begin
    sum = $signed({2'b00, base}) + $signed({{(SW-5){lut_data[4]}}, lut_data});
    if (sum < 0)
      wrapped = sum + NB_S;
    else if (sum >= NB_S)
      wrapped = sum - NB_S;
    else
      wrapped = sum;
  end

  assign busy     = (state != IDLE);
  assign lut_addr = (state == RUN) ? addr : 8'd0;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= 8'd0;
      base      <= '0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_idx   <= 8'd0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= fin;
      err  <= err_d;
      if (accept) begin
        base <= base_bin;
        addr <= 8'd0;
      end
      if (kill) begin
        out_valid <= 1'b0;
        addr      <= 8'd0;
      end else if (load) begin
        out_valid <= 1'b1;
        out_bin   <= wrapped[BIN_W-1:0];
        out_idx   <= addr;
        out_last  <= (addr == 8'hff);
        if (addr != 8'hff) addr <= addr + 8'd1;
      end else if (fin) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dir_lut_sweep_ctrl.sv
// Scoreboard bench for dir_lut_sweep_ctrl: stimulus pushes expected beats, a negedge monitor
// pops and compares on every handshake and watches payload stability and done/err pulses.
module tb_dir_lut_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, out_ready;
  logic [5:0] base_bin;
  logic       busy, done, err, out_valid, out_last;
  logic [7:0] lut_addr, out_idx;
  logic [4:0] lut_data;
  logic [5:0] out_bin;

  typedef struct {
    int bin;
    int idx;
    int last;
  } beat_t;

  beat_t sb[$];
  int total = 0, bad = 0;
  int cyc = 0, hs_cnt = 0, done_cnt = 0;
  int hs0_cyc = 0, hs_last_cyc = -10;
  logic stall_prev = 1'b0, abort_prev = 1'b0;
  logic [5:0] bin_prev;
  logic [7:0] idx_prev;
  logic       last_prev;

  always #5 clk = ~clk;

  dir_lut_sweep_ctrl #(.NBINS(36), .BIN_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_bin(base_bin), .abort(abort),
    .busy(busy), .done(done), .err(err), .lut_addr(lut_addr), .lut_data(lut_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
    .out_idx(out_idx), .out_last(out_last)
  );

  // Bench LUT: three fixed entries used by the directed expectations, a simple pattern elsewhere.
  function automatic logic [4:0] lut_fn(input logic [7:0] a);
    int v;
    case (a)
      8'd0:    return 5'd6;
      8'd8:    return 5'h1f;
      8'd192:  return 5'd9;
      default: begin
        v = (int'(a) * 7 + 3) % 32;
        return v[4:0];
      end
    endcase
  endfunction

  assign lut_data = lut_fn(lut_addr);

  function automatic int model_bin(input int base, input int idx);
    int off, s;
    off = int'(lut_fn(idx[7:0]));
    if (off >= 16) off -= 32;
    s = base + off;
    if (s < 0) s += 36;
    else if (s >= 36) s -= 36;
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_sweep(input int base, input int count);
    beat_t b;
    for (int i = 0; i < count; i++) begin
      b.bin  = model_bin(base, i);
      b.idx  = i;
      b.last = (i == 255) ? 1 : 0;
      sb.push_back(b);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int b);
    start    = 1'b1;
    base_bin = b[5:0];
    step();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_cnt;
    for (int c = 0; c < budget && done_cnt == d0; c++) step();
    check({name, "_done_seen"}, done_cnt - d0, 1);
  endtask

  // Monitor: handshakes, stall stability, done timing.
  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got idx %0d expected none", out_idx);
        end else begin
          e = sb.pop_front();
          check("beat_idx", int'(out_idx), e.idx);
          check("beat_bin", int'(out_bin), e.bin);
          check("beat_last", int'(out_last), e.last);
        end
        if (out_idx == 8'd0) hs0_cyc = cyc;
        if (out_last) hs_last_cyc = cyc;
      end
      if (stall_prev && !abort_prev) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_bin", int'(out_bin), int'(bin_prev));
        check("stall_idx", int'(out_idx), int'(idx_prev));
        check("stall_last", int'(out_last), int'(last_prev));
      end
      if (done) begin
        done_cnt++;
        check("done_timing", cyc, hs_last_cyc + 1);
      end
      if (done || err) check("err_done_excl", int'(done && err), 0);
      stall_prev = out_valid && !out_ready;
      abort_prev = abort;
      bin_prev   = out_bin;
      idx_prev   = out_idx;
      last_prev  = out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic check_idle_outputs(input string name);
    check({name, "_valid"}, int'(out_valid), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_done"}, int'(done), 0);
    check({name, "_err"}, int'(err), 0);
    check({name, "_addr"}, int'(lut_addr), 0);
    check({name, "_bin"}, int'(out_bin), 0);
    check({name, "_idx"}, int'(out_idx), 0);
    check({name, "_last"}, int'(out_last), 0);
  endtask

  initial begin
    int d0, h0;
    bit held;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1; base_bin = '0;
    step(); step();
    check_idle_outputs("por");
    rst_n = 1'b1;
    step();

    // T1: reset mid-sweep
    push_sweep(0, 256);
    do_start(0);
    repeat (20) step();
    check("t1_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    step(); step();
    check_idle_outputs("t1_rst");
    rst_n = 1'b1;
    sb.delete();
    step();

    // T2: full sweep base 0, back-to-back
    push_sweep(0, 256);
    h0 = hs_cnt;
    do_start(0);
    check("t2_busy", int'(busy), 1);
    check("t2_valid_lat", int'(out_valid), 0);
    step();
    check("t2_first_valid", int'(out_valid), 1);
    check("t2_first_bin", int'(out_bin), 6);
    wait_done("t2", 400);
    check("t2_beats", hs_cnt - h0, 256);
    check("t2_back_to_back", hs_last_cyc - hs0_cyc, 255);
    check("t2_sb_empty", sb.size(), 0);
    check("t2_busy_after", int'(busy), 0);

    // T3: high base forces wrap
    push_sweep(35, 256);
    do_start(35);
    step();
    check("t3_first_bin", int'(out_bin), 5);
    wait_done("t3", 400);
    check("t3_sb_empty", sb.size(), 0);

    // T4: random backpressure with a 10-cycle stall at idx100
    push_sweep(17, 256);
    h0 = hs_cnt;
    d0 = done_cnt;
    held = 1'b0;
    do_start(17);
    for (int c = 0; c < 3000 && done_cnt == d0; c++) begin
      if (!held && out_valid && out_idx == 8'd100) begin
        out_ready = 1'b0;
        repeat (10) step();
        held = 1'b1;
        out_ready = 1'b1;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      step();
    end
    out_ready = 1'b1;
    repeat (5) step();
    check("t4_stall_hit", int'(held), 1);
    check("t4_done_once", done_cnt - d0, 1);
    check("t4_beats", hs_cnt - h0, 256);
    check("t4_sb_empty", sb.size(), 0);

    // T5: abort while idx40 is presented
    push_sweep(0, 40);
    d0 = done_cnt;
    do_start(0);
    for (int c = 0; c < 200 && !(out_valid && out_idx == 8'd40); c++) step();
    check("t5_reached_idx40", int'(out_idx), 40);
    out_ready = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    out_ready = 1'b1;
    check("t5_valid_off", int'(out_valid), 0);
    check("t5_busy_off", int'(busy), 0);
    repeat (5) step();
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_sb_empty", sb.size(), 0);
    push_sweep(3, 256);
    do_start(3);
    step();
    check("t5_restart_idx", int'(out_idx), 0);
    check("t5_restart_bin", int'(out_bin), 9);
    wait_done("t5", 400);

    // T6: rejected base, then start while busy
    do_start(36);
    check("t6_err", int'(err), 1);
    check("t6_busy", int'(busy), 0);
    step();
    check("t6_err_pulse", int'(err), 0);
    push_sweep(5, 256);
    h0 = hs_cnt;
    do_start(5);
    repeat (10) step();
    start = 1'b1; base_bin = 6'd7;
    repeat (3) step();
    start = 1'b0;
    wait_done("t6", 400);
    repeat (5) step();
    check("t6_beats", hs_cnt - h0, 256);
    check("t6_sb_empty", sb.size(), 0);
    check("t6_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
